pc_fetch_sequencer: RTL

- Owns the program counter of the 32-bit MIPS datapath and sequences instruction fetch over a request/acknowledge handshake with instruction memory.
- Each cycle it selects the next PC from four sources: sequential, branch, jump (the zero-extended 26-bit target) and jr register.
- Sits between instruction memory and the decode/control unit. Provides PC, instruction-valid timing and a retired-instruction count.
- The PC is word-addressed: sequential increment is +1 and the jump target is the 26-bit field zero-extended to 32 bits.

---
 rtl/pc_fetch_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer for the word-addressed MIPS datapath.
// Optional macro PC_FETCH_DELAY_SLOT_EN: redirects take effect after one delay-slot instruction.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fetch_req,
   input  logic             fetch_ack,
   output logic [31:0]      pc_out,
   output logic             instr_valid,
   input  logic             stall,
   input  logic             jump_en,
   input  logic [25:0]      target_address,
   input  logic             branch_en,
   input  logic             branch_taken,
   input  logic [15:0]      branch_offset,
   input  logic             jr_en,
   input  logic [31:0]      jr_addr,
   input  logic             halt,
   output logic             halted,
   output logic [CNT_W-1:0] retired_count
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             instr_valid_q, instr_valid_d;

   logic [31:0]        seq_pc;
   logic [31:0]        redir_pc;
   logic               redir;
   logic signed [31:0] branch_disp;

`ifdef PC_FETCH_DELAY_SLOT_EN
   logic [31:0] pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;
`endif

   function automatic logic signed [31:0] sign_ext16(input logic signed [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         cnt_q         <= '0;
         instr_valid_q <= 1'b0;
`ifdef PC_FETCH_DELAY_SLOT_EN
         pend_q        <= '0;
         pend_vld_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         instr_valid_q <= instr_valid_d;
`ifdef PC_FETCH_DELAY_SLOT_EN
         pend_q        <= pend_d;
         pend_vld_q    <= pend_vld_d;
`endif
      end
   end

   // Redirect target selection; lower-priority requests are simply dropped
   always_comb begin
      seq_pc      = pc_q + 32'd1;
      branch_disp = sign_ext16(branch_offset);
      redir       = 1'b1;
      redir_pc    = seq_pc;
      if (jr_en) begin
         redir_pc = jr_addr;
      end else if (jump_en) begin
         redir_pc = {6'b0, target_address};
      end else if (branch_en && branch_taken) begin
         redir_pc = seq_pc + $unsigned(branch_disp);
      end else begin
         redir = 1'b0;
      end
   end

   // Next-state and next-PC logic
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cnt_d         = cnt_q;
      instr_valid_d = 1'b0;
`ifdef PC_FETCH_DELAY_SLOT_EN
      pend_d        = pend_q;
      pend_vld_d    = pend_vld_q;
`endif
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (fetch_ack) begin
               state_d       = S_EXEC;
               instr_valid_d = 1'b1;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               if (halt) begin
                  state_d = S_HALT;
`ifdef PC_FETCH_DELAY_SLOT_EN
                  pend_vld_d = 1'b0;
`endif
               end else begin
                  state_d = S_FETCH;
                  cnt_d   = cnt_q + CNT_W'(1);
`ifdef PC_FETCH_DELAY_SLOT_EN
                  // A retiring delay slot always follows the stored redirect
                  if (pend_vld_q) begin
                     pc_d       = pend_q;
                     pend_vld_d = 1'b0;
                  end else if (redir) begin
                     pc_d       = seq_pc;
                     pend_d     = redir_pc;
                     pend_vld_d = 1'b1;
                  end else begin
                     pc_d = seq_pc;
                  end
`else
                  pc_d = redir ? redir_pc : seq_pc;
`endif
               end
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      fetch_req     = (state_q == S_FETCH);
      halted        = (state_q == S_HALT);
      pc_out        = pc_q;
      instr_valid   = instr_valid_q;
      retired_count = cnt_q;
   end

endmodule
